// File: rtl/round_robin_sm_arbiter_if.sv
// Request/target bundle for the round-robin arbiter.
// slave: arbiter side; master: requester/target side.
interface round_robin_sm_arbiter_if #(
  parameter int N = 32,
  parameter int M = 8
);
  logic [3:0]   start_request;
  logic [N-1:0] input_arguments_0;
  logic [N-1:0] input_arguments_1;
  logic [N-1:0] input_arguments_2;
  logic [N-1:0] input_arguments_3;
  logic         target_state_machine_finished;
  logic [M-1:0] received_data;
  logic         start_target_state_machine;
  logic [N-1:0] output_arguments;
  logic [3:0]   reset_start_request;
  logic [3:0]   finish;
  logic [M-1:0] received_data_0;
  logic [M-1:0] received_data_1;
  logic [M-1:0] received_data_2;
  logic [M-1:0] received_data_3;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout;

  modport slave (
    input  start_request,
    input  input_arguments_0,
    input  input_arguments_1,
    input  input_arguments_2,
    input  input_arguments_3,
    input  target_state_machine_finished,
    input  received_data,
    output start_target_state_machine,
    output output_arguments,
    output reset_start_request,
    output finish,
    output received_data_0,
    output received_data_1,
    output received_data_2,
    output received_data_3,
    output grant_id,
    output busy,
    output timeout
  );

  modport master (
    output start_request,
    output input_arguments_0,
    output input_arguments_1,
    output input_arguments_2,
    output input_arguments_3,
    output target_state_machine_finished,
    output received_data,
    input  start_target_state_machine,
    input  output_arguments,
    input  reset_start_request,
    input  finish,
    input  received_data_0,
    input  received_data_1,
    input  received_data_2,
    input  received_data_3,
    input  grant_id,
    input  busy,
    input  timeout
  );
endinterface

// File: rtl/round_robin_sm_arbiter.sv
// Round-robin arbiter sharing one target FSM among
// four requesters, with per-requester result registers.
module round_robin_sm_arbiter #(
  parameter int N       = 32,
  parameter int M       = 8,
  parameter int TIMEOUT = 1024
) (
  input logic clk,
  input logic reset,
  round_robin_sm_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE, START, WAIT, FINISH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      p_q;
  logic [1:0]      grant_q;
  logic [1:0]      pick;
  logic [1:0]      idx;
  logic            found;
  logic [CW-1:0]   cnt_q;
  logic            abort_q;
  logic [M-1:0]    rd_q [4];
  logic            done;
  logic            expire;
  logic            run;
  logic [3:0]      gsel;
  logic [N-1:0]    args;

  // first set request scanning upward from p
  always_comb begin
    pick  = p_q;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = p_q + 2'(i);
      if (!found && bus.start_request[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign done   = (state_q == WAIT) &&
                  bus.target_state_machine_finished;
  assign expire = (state_q == WAIT) &&
                  !bus.target_state_machine_finished &&
                  (cnt_q == TMAX);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (done || expire) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      for (int k = 0; k < 4; k++) rd_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) grant_q <= pick;
      if (state_q == START) begin
        cnt_q   <= '0;
        abort_q <= 1'b0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (expire) abort_q <= 1'b1;
      if (done) rd_q[grant_q] <= bus.received_data;
      if (state_q == FINISH) p_q <= grant_q + 2'd1;
    end
  end

  always_comb begin
    args = '0;
    if (run && state_q != IDLE) begin
      unique case (grant_q)
        2'd0: args = bus.input_arguments_0;
        2'd1: args = bus.input_arguments_1;
        2'd2: args = bus.input_arguments_2;
        2'd3: args = bus.input_arguments_3;
        default: args = '0;
      endcase
    end
  end

  // outputs are held quiet while reset is asserted
  assign run  = !reset;
  assign gsel = 4'b0001 << grant_q;

  assign bus.start_target_state_machine =
    run && (state_q == START);
  assign bus.reset_start_request =
    (run && state_q == START) ? gsel : 4'b0;
  assign bus.finish =
    (run && state_q == FINISH) ? gsel : 4'b0;
  assign bus.timeout =
    run && (state_q == FINISH) && abort_q;
  assign bus.busy     = run && (state_q != IDLE);
  assign bus.grant_id = grant_q;
  assign bus.output_arguments = args;
  assign bus.received_data_0  = rd_q[0];
  assign bus.received_data_1  = rd_q[1];
  assign bus.received_data_2  = rd_q[2];
  assign bus.received_data_3  = rd_q[3];
endmodule

// File: doc/round_robin_sm_arbiter.md
ROUND_ROBIN_SM_ARBITER -- requirements
Module: round_robin_sm_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, width of each argument bus.
REQ-002 SHALL have parameter M, default 8, width of target result data.
REQ-003 SHALL have parameter TIMEOUT, default 1024, maximum WAIT cycles before abort (TIMEOUT >= 2).
REQ-004 clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_request  in  4  per-requester start request, bit k = requester k.
REQ-007 input_arguments_0..3  in  N each  argument bus of requester k.
REQ-008 target_state_machine_finished  in  1  done pulse/level from shared target FSM.
REQ-009 received_data  in  M  result from target, valid while finished is high.
REQ-010 start_target_state_machine  out  1  one-cycle start pulse to target.
REQ-011 output_arguments  out  N  arguments of granted requester.
REQ-012 reset_start_request  out  4  one-hot one-cycle clear of requester k's trapped request.
REQ-013 finish  out  4  one-hot one-cycle completion pulse to requester k.
REQ-014 received_data_0..3  out  M each  registered last result for requester k.
REQ-015 grant_id  out  2  index of requester currently served.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 timeout  out  1  one-cycle pulse, coincident with finish, when a transaction aborts.

Function
REQ-018 SHALL implement states IDLE, START, WAIT, FINISH, registered.
REQ-019 IDLE: SHALL sample start_request; if nonzero, select first set bit scanning from priority pointer p upward modulo 4, load grant_id, go START; else stay IDLE.
REQ-020 START (1 cycle): start_target_state_machine=1, reset_start_request[grant_id]=1; go WAIT.
REQ-021 WAIT: counter increments each cycle from 0; if target_state_machine_finished=1 SHALL load received_data into received_data_<grant_id> on that edge and go FINISH.
REQ-022 WAIT: if finished=0 and counter = TIMEOUT-1, SHALL go FINISH with abort flag set; result register unchanged.
REQ-023 Finished and timeout on same cycle: finished wins, no timeout pulse.
REQ-024 FINISH (1 cycle): finish[grant_id]=1, timeout=abort flag; p <= grant_id+1 mod 4 (3 wraps to 0); go IDLE.
REQ-025 output_arguments SHALL equal input_arguments_<grant_id> in START, WAIT, FINISH; 0 in IDLE.
REQ-026 Latency: request sampled in IDLE at cycle 0 -> start pulse cycle 1; finished in first WAIT cycle (cycle 2) -> finish pulse and updated data visible cycle 3; IDLE cycle 4.
REQ-027 target_state_machine_finished SHALL be ignored outside WAIT.
REQ-028 start_request changes outside IDLE SHALL have no effect until next IDLE.
REQ-029 Only one requester served per transaction; at most one bit of reset_start_request/finish high at any time.
REQ-030 Non-granted received_data_k registers SHALL hold their value.
REQ-031 With all four requesting continuously, service order SHALL be p, p+1, p+2, p+3 (mod 4), no requester starved more than 3 transactions.

Reset
REQ-032 reset high at a posedge SHALL force IDLE, p=0, grant_id=0, counter=0, abort flag=0, all received_data_k=0.
REQ-033 While in/after reset all pulse outputs, busy, timeout, output_arguments SHALL be 0.
REQ-034 Reset mid-transaction (START/WAIT/FINISH) SHALL abort without finish pulse or data capture; pending requests re-arbitrated from p=0.

Verification
REQ-035 Single request: start_request=0010, args_1=0xDEADBEEF, finished+data=0x5A in first WAIT cycle -> start pulse cycle 1 with output_arguments=0xDEADBEEF, reset_start_request=0010 cycle 1, finish=0010 and received_data_1=0x5A cycle 3.
REQ-036 Round-robin: start_request=1111 held, target finishes after 2 WAIT cycles -> grant order 0,1,2,3,0; finish pulses one-hot in that order.
REQ-037 Wrap priority: serve requester 3, then start_request=0101 -> requester 0 granted next, then 2.
REQ-038 Timeout: TIMEOUT=8, finished never asserted -> finish and timeout pulse after 8 WAIT cycles, received_data_k unchanged; finished on cycle 8 -> no timeout.
REQ-039 Reset in WAIT: assert reset one cycle -> busy=0 next cycle, no finish pulse, data registers 0, subsequent request served from p=0.
REQ-040 Stray done: finished pulsed while IDLE with start_request=0 -> no outputs change, remains IDLE.
